// File: rtl/imem_axil_rd_slave_pkg.sv
// Shared bus widths, address window, AXI response codes and read-FSM encoding
// for the instruction-memory AXI-lite read slave.
package imem_axil_rd_slave_pkg;

  localparam int          IMEM_ADDR_W   = 32;
  localparam int          IMEM_DATA_W   = 64;
  localparam logic [31:0] IMEM_MEM_BASE = 32'h8000_0000;
  localparam logic [31:0] IMEM_MEM_SIZE = 32'h0800_0000;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_READ = 2'd2,
    S_HOLD = 2'd3
  } rd_state_e;

endpackage

// File: rtl/imem_axil_rd_slave_addr_fifo.sv
// Outstanding read-address FIFO: DEPTH entries of {oor, addr}, with
// simultaneous push and pop allowed whenever the FIFO is not full.
module imem_addr_fifo
  import imem_axil_rd_slave_pkg::*;
#(
  parameter int W     = IMEM_ADDR_W + 1,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wr_ptr;
  logic [PW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (count == '0);
  assign full    = (count == (PW + 1)'(DEPTH));
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/imem_axil_rd_slave.sv
// Read-only AXI-lite slave feeding the fetch stage from a synchronous-read
// instruction memory. Optional randomised response delay: IMEM_RAND_DELAY_EN.
//
// state  | meaning
// IDLE   | no outstanding address at the FIFO head
// WAIT   | latency countdown for the head entry
// READ   | memory read strobe (suppressed for out-of-range entries)
// HOLD   | beat presented on R until RREADY
module imem_axil_rd_slave
  import imem_axil_rd_slave_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter int                DEPTH    = 2,
  parameter int                LATENCY  = 1,
  parameter logic [ADDR_W-1:0] MEM_BASE = ADDR_W'(IMEM_MEM_BASE),
  parameter logic [ADDR_W-1:0] MEM_SIZE = ADDR_W'(IMEM_MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ARVALID,
  input  logic [ADDR_W-1:0] ARADDR,
  output logic              ARREADY,
  output logic              RVALID,
  input  logic              RREADY,
  output logic [DATA_W-1:0] RDATA,
  output logic [1:0]        RRESP,
  output logic              mem_ren,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int                CW         = $clog2(DEPTH) + 1;
  localparam int                CNT_W      = 5;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(DATA_W / 8 - 1);

  rd_state_e         state;
  rd_state_e         state_d;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_d;
  logic [CNT_W-1:0]  cnt_load;
  logic              first_q;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_now;
  logic [ADDR_W:0]   ar_off;
  logic              ar_oor;
  logic              push;
  logic              pop;
  logic              more;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [ADDR_W:0]   head;
  logic              head_oor;
  logic [ADDR_W-1:0] head_addr;

  // One extra bit so an address below the base shows up as a borrow.
  assign ar_off  = {1'b0, ARADDR} - {1'b0, MEM_BASE};
  assign ar_oor  = ar_off[ADDR_W] | (ar_off[ADDR_W-1:0] >= MEM_SIZE);

  assign ARREADY = rst & ~fifo_full;
  assign push    = ARVALID & ARREADY;
  assign RVALID  = (state == S_HOLD);
  assign pop     = RVALID & RREADY;
  assign more    = (fifo_count > CW'(1)) | push;

  imem_addr_fifo #(
    .W     (ADDR_W + 1),
    .DEPTH (DEPTH)
  ) u_addr_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({ar_oor, ARADDR}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign {head_oor, head_addr} = head;
  assign mem_raddr = head_addr & ALIGN_MASK;

`ifdef IMEM_RAND_DELAY_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk) begin
    if (!rst) lfsr <= 8'hA5;
    else      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign cnt_load = CNT_W'(LATENCY) + CNT_W'(lfsr[2:0]);
`else
  assign cnt_load = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      cnt     <= '0;
      first_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      first_q <= (state == S_READ);
      if (state == S_HOLD && first_q) rdata_q <= rdata_now;
    end
  end

  // Memory data arrives in the first HOLD cycle; it is passed through then
  // and served from rdata_q for the rest of a stalled beat.
  assign rdata_now = head_oor ? '0 : mem_rdata;
  assign RDATA     = (state == S_HOLD && first_q) ? rdata_now : rdata_q;
  assign RRESP     = (state == S_HOLD && head_oor) ? RESP_SLVERR : RESP_OKAY;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    mem_ren = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d = S_WAIT;
          cnt_d   = cnt_load;
        end
      end
      S_WAIT: begin
        if (cnt <= CNT_W'(1)) state_d = S_READ;
        else                  cnt_d   = cnt - CNT_W'(1);
      end
      S_READ: begin
        mem_ren = ~head_oor;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (RREADY) begin
          if (more) begin
            state_d = S_WAIT;
            cnt_d   = cnt_load;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_axil_rd_slave.sv
// Directed self-checking bench for imem_axil_rd_slave with a synchronous
// memory model; the random-delay latency loop runs under IMEM_RAND_DELAY_EN.
module tb_imem_axil_rd_slave;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        ARVALID;
  logic [31:0] ARADDR;
  logic        ARREADY;
  logic        RVALID;
  logic        RREADY;
  logic [63:0] RDATA;
  logic [1:0]  RRESP;
  logic        mem_ren;
  logic [31:0] mem_raddr;
  logic [63:0] mem_rdata;

  int          errors = 0;
  int          checks = 0;
  int          ren_count = 0;
  logic [31:0] last_raddr;
  logic        last_ar_hs = 1'b0;

  always #5 clk = ~clk;

  imem_axil_rd_slave #(.LATENCY(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .ARVALID   (ARVALID),
    .ARADDR    (ARADDR),
    .ARREADY   (ARREADY),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .RDATA     (RDATA),
    .RRESP     (RRESP),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 64'h0000_0013_0000_0093;
    return {~a, a};
  endfunction

  // Synchronous-read memory: data valid the cycle after mem_ren.
  always @(posedge clk) begin
    if (!rst) mem_rdata <= '0;
    else if (mem_ren) begin
      mem_rdata  <= mem_word(mem_raddr);
      last_raddr <= mem_raddr;
      ren_count  <= ren_count + 1;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic hs;
    hs = ARVALID && ARREADY;
    @(posedge clk);
    #1;
    last_ar_hs = hs;
    if (hs) ARVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    ARADDR  = a;
    ARVALID = 1'b1;
  endtask

  task automatic ar_wait(input string tag);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!last_ar_hs && n < 20);
    check(tag, 64'(last_ar_hs), 64'd1);
  endtask

  task automatic wait_rvalid(output int n);
    n = 0;
    while (!RVALID && n < 40) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n;
    int          r0;
    int          sent;
    int          got;
    int          cyc;
    logic        seen;
    logic        prev_stall;
    logic [63:0] prev_data;
    logic [31:0] al;
    logic [63:0] exp_q[$];

    rst = 1'b0; ARVALID = 1'b0; ARADDR = '0; RREADY = 1'b0;
    repeat (3) tick();
    check("rst_rvalid",  64'(RVALID),  64'd0);
    check("rst_rdata",   RDATA,        64'd0);
    check("rst_rresp",   64'(RRESP),   64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_arready", 64'(ARREADY), 64'd0);
    rst = 1'b1;
    tick();
    check("rel_arready", 64'(ARREADY), 64'd1);

    // Single aligned fetch, RREADY held high.
    RREADY = 1'b1;
    send_ar(32'h8000_0000);
    ar_wait("ar0_hs");
    wait_rvalid(n);
    check("lat0",       64'(n),          64'(2 + LAT));
    check("rdata0",     RDATA,           64'h0000_0013_0000_0093);
    check("rresp0",     64'(RRESP),      64'd0);
    check("raddr0",     64'(last_raddr), 64'h8000_0000);
    tick();
    check("rvalid_drop", 64'(RVALID),    64'd0);

    // Unaligned fetch returns the whole aligned beat.
    send_ar(32'h8000_0004);
    ar_wait("ar1_hs");
    wait_rvalid(n);
    check("lat1",   64'(n),          64'(2 + LAT));
    check("raddr1", 64'(last_raddr), 64'h8000_0000);
    check("rdata1", RDATA,           64'h0000_0013_0000_0093);
    tick();

    // Fill the FIFO with RREADY low; third address must be held off.
    RREADY = 1'b0;
    send_ar(32'h8000_0100);
    ar_wait("arA_hs");
    send_ar(32'h8000_0208);
    ar_wait("arB_hs");
    send_ar(32'h8000_0310);
    repeat (4) tick();
    check("full_arready", 64'(ARREADY), 64'd0);
    check("full_arheld",  64'(ARVALID), 64'd1);
    wait_rvalid(n);
    check("stallA_data0", RDATA, 64'h7FFF_FEFF_8000_0100);
    repeat (3) tick();
    check("stallA_valid", 64'(RVALID), 64'd1);
    check("stallA_data",  RDATA,       64'h7FFF_FEFF_8000_0100);
    check("stallA_resp",  64'(RRESP),  64'd0);
    RREADY = 1'b1;
    tick();
    check("no_push_on_full_pop", 64'(last_ar_hs), 64'd0);
    ar_wait("arC_hs");
    wait_rvalid(n);
    check("beatB", RDATA, 64'h7FFF_FDF7_8000_0208);
    tick();
    wait_rvalid(n);
    check("beatC", RDATA, 64'h7FFF_FCEF_8000_0310);
    tick();

    // Out-of-range addresses: no memory read, SLVERR, zero data.
    r0 = ren_count;
    send_ar(32'h7FFF_FFFC);
    ar_wait("arLo_hs");
    wait_rvalid(n);
    check("oorLo_resp", 64'(RRESP), 64'd2);
    check("oorLo_data", RDATA,      64'd0);
    tick();
    send_ar(32'hFFFF_FFF8);
    ar_wait("arHi_hs");
    wait_rvalid(n);
    check("oorHi_resp", 64'(RRESP), 64'd2);
    check("oorHi_data", RDATA,      64'd0);
    tick();
    send_ar(32'h8800_0000);
    ar_wait("arEnd_hs");
    wait_rvalid(n);
    check("oorEnd_resp", 64'(RRESP), 64'd2);
    tick();
    check("oor_no_ren", 64'(ren_count), 64'(r0));
    send_ar(32'h87FF_FFF8);
    ar_wait("arLast_hs");
    wait_rvalid(n);
    check("last_resp", 64'(RRESP), 64'd0);
    check("last_data", RDATA,      64'h7800_0007_87FF_FFF8);
    tick();
    send_ar(32'h8000_0020);
    ar_wait("arD_hs");
    wait_rvalid(n);
    check("okD_resp", 64'(RRESP), 64'd0);
    check("okD_data", RDATA,      64'h7FFF_FFDF_8000_0020);
    tick();

    // Reset while holding a beat with a second entry queued.
    RREADY = 1'b0;
    send_ar(32'h8000_0100);
    ar_wait("arR1_hs");
    send_ar(32'h8000_0208);
    ar_wait("arR2_hs");
    wait_rvalid(n);
    check("pre_rst_valid", 64'(RVALID), 64'd1);
    rst = 1'b0;
    tick();
    check("midrst_rvalid",  64'(RVALID),  64'd0);
    check("midrst_arready", 64'(ARREADY), 64'd0);
    check("midrst_rdata",   RDATA,        64'd0);
    tick();
    rst = 1'b1;
    RREADY = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (RVALID) seen = 1'b1;
    end
    check("no_stale_beat", 64'(seen), 64'd0);
    send_ar(32'h8000_0040);
    ar_wait("arE_hs");
    wait_rvalid(n);
    check("latE",  64'(n), 64'(2 + LAT));
    check("dataE", RDATA,  64'h7FFF_FFBF_8000_0040);
    tick();
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (RVALID) seen = 1'b1;
    end
    check("only_own_beat", 64'(seen), 64'd0);

    // Random AR issue and RREADY back-pressure: order and R stability.
    sent = 0; got = 0; cyc = 0;
    prev_stall = 1'b0; prev_data = '0; last_ar_hs = 1'b0;
    while (got < 40 && cyc < 3000) begin
      if (last_ar_hs) begin
        al = ARADDR & 32'hFFFF_FFF8;
        exp_q.push_back(mem_word(al));
      end
      if (prev_stall) begin
        check("stall_valid", 64'(RVALID), 64'd1);
        check("stall_data",  RDATA,       prev_data);
      end
      if (!ARVALID && sent < 40 && $urandom_range(0, 2) != 0) begin
        ARADDR  = 32'h8000_1000 + 32'(sent * 8) + ((sent % 3 == 0) ? 32'd4 : 32'd0);
        ARVALID = 1'b1;
        sent++;
      end
      RREADY = 1'($urandom_range(0, 1));
      if (RVALID && RREADY) begin
        if (exp_q.size() > 0) check("rand_order", RDATA, exp_q.pop_front());
        else                  check("rand_extra", 64'(RVALID), 64'd0);
        check("rand_resp", 64'(RRESP), 64'd0);
        got++;
      end
      prev_stall = RVALID && !RREADY;
      prev_data  = RDATA;
      tick();
      cyc++;
    end
    check("rand_done",  64'(got),          64'd40);
    check("rand_drain", 64'(exp_q.size()), 64'd0);
    RREADY = 1'b1;
    repeat (10) tick();

`ifdef IMEM_RAND_DELAY_EN
    for (int i = 0; i < 100; i++) begin
      send_ar(32'h8000_2000 + 32'(i * 8));
      ar_wait("rd_ar_hs");
      wait_rvalid(n);
      check("rd_lat_range", 64'((n >= 2 + LAT) && (n <= 9 + LAT)), 64'd1);
      check("rd_data", RDATA, mem_word(32'h8000_2000 + 32'(i * 8)));
      tick();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
